// File: rtl/fpu_stream_pkg.sv
// Shared types and constants for the FP16 subtract stream shell.
//   FP16_W          : FP16 word width
//   fp16_t          : FP16 word
//   result_entry_t  : buffered result entry {err, data}
//   FP16_QNAN_NEG / FP16_ONE : well-known FP16 encodings
package fpu_stream_pkg;

    localparam int unsigned FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    typedef struct packed {
        logic  err;
        fp16_t data;
    } result_entry_t;

    localparam int unsigned RESULT_ENTRY_W = $bits(result_entry_t);

    localparam fp16_t FP16_QNAN_NEG = 16'hFE00;
    localparam fp16_t FP16_ONE      = 16'h3C00;

endpackage

// File: rtl/fpu_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears pointers and count)
//   push_i  : write data_i this cycle
//   data_i  : write data
//   pop_i   : consume head entry (ignored while empty)
//   data_o  : head entry, zero while empty
//   valid_o : FIFO non-empty
//   count_o : number of stored entries
module fpu_sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Pointer increment wrapping modulo DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // Next-state pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the cleared count hides stale entries
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Writing a full FIFO is only legal when the head leaves in the same cycle
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_no_overflow: assert (!(push_i && !do_pop && (count_q == CNT_W'(DEPTH))));
        end
    end

endmodule

// File: rtl/fpu_sub_stream_ctrl.sv
// AXI-Stream flow-control shell around the fixed-latency FP16 subtract pipe.
// Joins the A/B operand streams, tracks in-flight pairs with a latency-matched
// shift register and buffers every retired result in a FWFT FIFO. Issue is
// gated by credit so the FIFO can never overflow.
//   aclk, areset          : clock, synchronous active-high reset
//   s_axis_a_* / s_axis_b_*: operand streams (FP16)
//   pipe_a/b_tdata, pipe_tvalid        : to the subtract pipe
//   pipe_result_tdata/tvalid           : from the subtract pipe
//   m_axis_result_*       : buffered results, tuser = 1 marks a pipe error
// Build option: FPU_ERR_DROP_EN drops error results (credit is still freed)
// and ties m_axis_result_tuser to 0.
module fpu_sub_stream_ctrl
    import fpu_stream_pkg::*;
#(
    parameter int unsigned PIPE_LATENCY = 6,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [15:0] s_axis_a_tdata,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [15:0] s_axis_b_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    output logic [15:0] pipe_a_tdata,
    output logic [15:0] pipe_b_tdata,
    output logic        pipe_tvalid,
    input  logic [15:0] pipe_result_tdata,
    input  logic        pipe_result_tvalid,
    output logic [15:0] m_axis_result_tdata,
    output logic        m_axis_result_tuser,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PIPE_LATENCY-1:0] issue_sr_q, issue_sr_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [CNT_W-1:0]        fifo_count;
    logic                    credit_ok;
    logic                    issue;
    logic                    retire;
    logic                    push;
    logic                    head_valid;
    result_entry_t           push_entry;
    result_entry_t           head_entry;

    // Every buffered or in-flight result holds one FIFO slot
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);

    // Join: both operands are consumed together or not at all
    assign issue           = s_axis_a_tvalid & s_axis_b_tvalid & credit_ok & ~areset;
    assign s_axis_a_tready = s_axis_b_tvalid & credit_ok & ~areset;
    assign s_axis_b_tready = s_axis_a_tvalid & credit_ok & ~areset;

    assign pipe_a_tdata = s_axis_a_tdata;
    assign pipe_b_tdata = s_axis_b_tdata;
    assign pipe_tvalid  = issue;

    // Pipe outputs are only trusted when a tracked issue reaches the end
    assign retire = issue_sr_q[PIPE_LATENCY-1];

`ifdef FPU_ERR_DROP_EN
    assign push       = retire & pipe_result_tvalid;
    assign push_entry = '{err: 1'b0, data: pipe_result_tdata};
`else
    assign push       = retire;
    assign push_entry = '{err: ~pipe_result_tvalid, data: pipe_result_tdata};
`endif

    // Issue tracking next state
    always_comb begin
        issue_sr_d = PIPE_LATENCY'({issue_sr_q, issue});
        inflight_d = inflight_q;
        case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            issue_sr_q <= '0;
            inflight_q <= '0;
        end else begin
            issue_sr_q <= issue_sr_d;
            inflight_q <= inflight_d;
        end
    end

    fpu_sync_fifo #(
        .WIDTH (RESULT_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_result_fifo (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (m_axis_result_tready),
        .data_o  (head_entry),
        .valid_o (head_valid),
        .count_o (fifo_count)
    );

    // Head entry is all-zero while the FIFO is empty
    assign m_axis_result_tvalid = head_valid;
    assign m_axis_result_tdata  = head_entry.data;
    assign m_axis_result_tuser  = head_entry.err;

endmodule

// File: tb/tb_fpu_sub_stream_ctrl.sv
// Directed bench for fpu_sub_stream_ctrl with a behavioural 6-cycle FP16
// subtract pipe stand-in (hand-tabulated results, garbage on idle slots).
module tb_fpu_sub_stream_ctrl;

    localparam int unsigned L     = 6;
    localparam int unsigned DEPTH = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [15:0] pipe_a, pipe_b;
    logic        pipe_v;
    logic [15:0] pres_d;
    logic        pres_v;
    logic [15:0] m_data;
    logic        m_user, m_valid, m_ready;

    always #5 aclk = ~aclk;

    fpu_sub_stream_ctrl #(.PIPE_LATENCY(L), .FIFO_DEPTH(DEPTH)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_a_tdata       (a_data),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tready      (a_ready),
        .s_axis_b_tdata       (b_data),
        .s_axis_b_tvalid      (b_valid),
        .s_axis_b_tready      (b_ready),
        .pipe_a_tdata         (pipe_a),
        .pipe_b_tdata         (pipe_b),
        .pipe_tvalid          (pipe_v),
        .pipe_result_tdata    (pres_d),
        .pipe_result_tvalid   (pres_v),
        .m_axis_result_tdata  (m_data),
        .m_axis_result_tuser  (m_user),
        .m_axis_result_tvalid (m_valid),
        .m_axis_result_tready (m_ready)
    );

    // Operand ladder (2.0 .. 13.0) and hand-computed (x - 1.0) results
    logic [15:0] lad_a [12] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700,
                                16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80};
    logic [15:0] lad_r [12] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
                                16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00};

    // Pipe stand-in: {ok, data} for a known operand pair
    function automatic logic [16:0] sub_model(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h7C00 && b == 16'h7C00) return {1'b0, 16'hFE00};
        if (b != 16'h3C00) return {1'b1, 16'h0BAD};
        case (a)
            16'h4000: return {1'b1, 16'h3C00};
            16'h4200: return {1'b1, 16'h4000};
            16'h4400: return {1'b1, 16'h4200};
            16'h4500: return {1'b1, 16'h4400};
            16'h4600: return {1'b1, 16'h4500};
            16'h4700: return {1'b1, 16'h4600};
            16'h4800: return {1'b1, 16'h4700};
            16'h4880: return {1'b1, 16'h4800};
            16'h4900: return {1'b1, 16'h4880};
            16'h4980: return {1'b1, 16'h4900};
            16'h4A00: return {1'b1, 16'h4980};
            16'h4A80: return {1'b1, 16'h4A00};
            default:  return {1'b1, 16'h0BAD};
        endcase
    endfunction

    logic [15:0] st_d  [L];
    logic        st_ok [L];

    // No reset: idle slots carry valid-looking garbage that must be ignored
    always @(posedge aclk) begin
        if (pipe_v) {st_ok[0], st_d[0]} <= sub_model(pipe_a, pipe_b);
        else begin
            st_ok[0] <= 1'b1;
            st_d[0]  <= 16'hDEAD;
        end
        for (int i = 1; i < L; i++) begin
            st_ok[i] <= st_ok[i-1];
            st_d[i]  <= st_d[i-1];
        end
    end
    assign pres_d = st_d[L-1];
    assign pres_v = st_ok[L-1];

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic        u;
    } rec_t;

    int   cyc = 0;
    int   iss_q [$];
    rec_t res_q [$];
    int   mv_cnt = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (pipe_v) iss_q.push_back(cyc);
        if (m_valid && m_ready) res_q.push_back('{cyc, m_data, m_user});
        if (m_valid) mv_cnt++;
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_logs;
        iss_q.delete();
        res_q.delete();
    endtask

    task automatic test_reset;
        areset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_data = 16'h4200; b_data = 16'h3C00; m_ready = 1'b1;
        repeat (8) tick;
        #1;
        checks++;
        if ({a_ready, b_ready, pipe_v} !== 3'b000)
            $display("FAIL reset_readys: got %b want 000", {a_ready, b_ready, pipe_v});
        else passes++;
        checks++;
        if ({m_valid, m_user, m_data} !== 18'h0)
            $display("FAIL reset_outputs: got v=%b u=%b d=%h want all 0", m_valid, m_user, m_data);
        else passes++;
        a_valid = 1'b0; b_valid = 1'b0;
        tick;
        areset = 1'b0;
        repeat (4) tick;
        checks++;
        if (m_valid !== 1'b0) $display("FAIL reset_idle_garbage: m_valid got %b want 0", m_valid);
        else passes++;
    endtask

    task automatic test_streaming;
        clear_logs();
        m_ready = 1'b1; a_data = 16'h4200; b_data = 16'h3C00;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (20) tick;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (12) tick;
        checks++;
        if (iss_q.size() != 20) $display("FAIL stream_issue_count: got %0d want 20", iss_q.size());
        else passes++;
        checks++;
        if (res_q.size() != 20) $display("FAIL stream_result_count: got %0d want 20", res_q.size());
        else passes++;
        if (iss_q.size() == 20 && res_q.size() == 20) begin
            checks++;
            if (iss_q[19] - iss_q[0] != 19)
                $display("FAIL stream_issue_span: got %0d want 19", iss_q[19] - iss_q[0]);
            else passes++;
            checks++;
            if (res_q[0].cyc - iss_q[0] != 7)
                $display("FAIL stream_latency: got %0d want 7", res_q[0].cyc - iss_q[0]);
            else passes++;
            for (int i = 0; i < 20; i++) begin
                checks++;
                if ({res_q[i].u, res_q[i].d} !== {1'b0, 16'h4000} || res_q[i].cyc != res_q[0].cyc + i)
                    $display("FAIL stream_result[%0d]: got u=%b d=%h cyc+%0d want u=0 d=4000 cyc+%0d",
                             i, res_q[i].u, res_q[i].d, res_q[i].cyc - res_q[0].cyc, i);
                else passes++;
            end
        end
    endtask

    task automatic test_join_skew;
        clear_logs();
        m_ready = 1'b1; a_data = 16'h4400; b_data = 16'h3C00;
        a_valid = 1'b1; b_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({a_ready, pipe_v} !== 2'b00)
                $display("FAIL skew_no_issue[%0d]: got a_ready/pipe_v=%b want 00", c, {a_ready, pipe_v});
            else passes++;
            if (c == 0) begin
                checks++;
                if ({pipe_a, pipe_b} !== {16'h4400, 16'h3C00})
                    $display("FAIL skew_passthrough: got %h %h want 4400 3c00", pipe_a, pipe_b);
                else passes++;
            end
            tick;
        end
        b_valid = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready, pipe_v} !== 3'b111)
            $display("FAIL skew_join: got %b want 111", {a_ready, b_ready, pipe_v});
        else passes++;
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (10) tick;
        checks++;
        if (iss_q.size() != 1) $display("FAIL skew_issue_count: got %0d want 1", iss_q.size());
        else passes++;
        checks++;
        if (res_q.size() != 1 || res_q[0].d !== 16'h4200)
            $display("FAIL skew_result: got n=%0d want 1 result 4200", res_q.size());
        else passes++;
    endtask

    task automatic test_backpressure;
        int  k;
        logic acc;
        clear_logs();
        k = 0;
        m_ready = 1'b0; b_data = 16'h3C00;
        for (int c = 0; c < 20; c++) begin
            a_valid = (k < 12); b_valid = (k < 12);
            a_data = lad_a[k % 12];
            #1;
            acc = a_ready & a_valid & b_valid;
            if (c == 19) begin
                checks++;
                if ({a_ready, b_ready} !== 2'b00)
                    $display("FAIL bp_readys_low: got %b want 00", {a_ready, b_ready});
                else passes++;
            end
            tick;
            if (acc) k++;
        end
        checks++;
        if (k != DEPTH) $display("FAIL bp_accepted: got %0d want %0d", k, DEPTH);
        else passes++;
        m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            a_valid = (k < 12); b_valid = (k < 12);
            a_data = lad_a[k % 12];
            #1;
            acc = a_ready & a_valid & b_valid;
            tick;
            if (acc) k++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (12) tick;
        checks++;
        if (iss_q.size() != 12) $display("FAIL bp_issue_count: got %0d want 12", iss_q.size());
        else passes++;
        if (iss_q.size() == 12) begin
            checks++;
            if (iss_q[11] - iss_q[8] != 3)
                $display("FAIL bp_resume_rate: got span %0d want 3", iss_q[11] - iss_q[8]);
            else passes++;
        end
        checks++;
        if (res_q.size() != 12) $display("FAIL bp_result_count: got %0d want 12", res_q.size());
        else passes++;
        for (int i = 0; i < 12 && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i].d !== lad_r[i])
                $display("FAIL bp_order[%0d]: got %h want %h", i, res_q[i].d, lad_r[i]);
            else passes++;
        end
    endtask

    task automatic test_error;
        clear_logs();
        m_ready = 1'b1; a_data = 16'h7C00; b_data = 16'h7C00;
        a_valid = 1'b1; b_valid = 1'b1;
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (10) tick;
        checks++;
        if (iss_q.size() != 1) $display("FAIL err_issue_count: got %0d want 1", iss_q.size());
        else passes++;
`ifndef FPU_ERR_DROP_EN
        checks++;
        if (res_q.size() != 1) $display("FAIL err_result_count: got %0d want 1", res_q.size());
        else passes++;
        if (res_q.size() == 1) begin
            checks++;
            if ({res_q[0].u, res_q[0].d} !== {1'b1, 16'hFE00})
                $display("FAIL err_tagged: got u=%b d=%h want u=1 d=fe00", res_q[0].u, res_q[0].d);
            else passes++;
        end
`else
        checks++;
        if (res_q.size() != 0) $display("FAIL err_dropped: got %0d results want 0", res_q.size());
        else passes++;
        m_ready = 1'b0; a_data = 16'h4200; b_data = 16'h3C00;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (8) tick;
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (iss_q.size() != 9) $display("FAIL err_credit_freed: got %0d issues want 9", iss_q.size());
        else passes++;
        m_ready = 1'b1;
        repeat (16) tick;
`endif
    endtask

    task automatic test_full_simul;
        int   k;
        int   t0;
        int   guard;
        logic acc;
        clear_logs();
        k = 0;
        m_ready = 1'b0; b_data = 16'h3C00;
        for (int c = 0; c < 8; c++) begin
            a_valid = 1'b1; b_valid = 1'b1; a_data = lad_a[k];
            #1;
            acc = a_ready;
            tick;
            if (acc) k++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (k != 8) $display("FAIL full_fill: got %0d accepted want 8", k);
        else passes++;
        t0 = (iss_q.size() > 0) ? iss_q[0] : cyc;
        guard = 0;
        while (cyc < t0 + 13 && guard < 50) begin
            tick;
            guard++;
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if ({m_valid, m_data} !== {1'b1, lad_r[0]})
            $display("FAIL full_head: got v=%b d=%h want v=1 d=%h", m_valid, m_data, lad_r[0]);
        else passes++;
        tick;
        m_ready = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = lad_a[8];
        #1;
        checks++;
        if (a_ready !== 1'b1) $display("FAIL full_one_credit: a_ready got %b want 1", a_ready);
        else passes++;
        tick;
        #1;
        checks++;
        if (a_ready !== 1'b0) $display("FAIL full_credit_spent: a_ready got %b want 0", a_ready);
        else passes++;
        a_valid = 1'b0; b_valid = 1'b0;
        m_ready = 1'b1;
        repeat (20) tick;
        checks++;
        if (res_q.size() != 9) $display("FAIL full_result_count: got %0d want 9", res_q.size());
        else passes++;
        if (res_q.size() > 0) begin
            checks++;
            if (res_q[0].cyc != t0 + 13)
                $display("FAIL full_pop_cycle: got %0d want %0d", res_q[0].cyc - t0, 13);
            else passes++;
        end
        for (int i = 0; i < 9 && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i].d !== lad_r[i])
                $display("FAIL full_order[%0d]: got %h want %h", i, res_q[i].d, lad_r[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_midflight;
        int mv0;
        clear_logs();
        m_ready = 1'b1; a_data = 16'h4200; b_data = 16'h3C00;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (3) tick;
        a_valid = 1'b0; b_valid = 1'b0;
        areset = 1'b1;
        tick;
        areset = 1'b0;
        mv0 = mv_cnt;
        b_valid = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) $display("FAIL rst_credit_restored: a_ready got %b want 1", a_ready);
        else passes++;
        tick;
        b_valid = 1'b0;
        repeat (15) tick;
        checks++;
        if (iss_q.size() != 3) $display("FAIL rst_issue_count: got %0d want 3", iss_q.size());
        else passes++;
        checks++;
        if (res_q.size() != 0 || mv_cnt != mv0)
            $display("FAIL rst_discard: got %0d results, %0d valid cycles want 0 and 0",
                     res_q.size(), mv_cnt - mv0);
        else passes++;
    endtask

    initial begin
        areset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0; m_ready = 1'b0;
        tick;
        test_reset();
        test_streaming();
        test_join_skew();
        test_backpressure();
        test_error();
        test_full_simul();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
